// File: rtl/burst_line_master_if.sv
// Host request/response and burst-RAM command signals for burst_line_master.
// master: the line master itself; slave: the host plus RAM environment driving it.
interface burst_line_master_if #(
  parameter int unsigned DEPTH_BITWIDTH = 4,
  parameter int unsigned DATA_BITWIDTH  = 64,
  parameter int unsigned BURST_COUNT    = 4
);
  localparam int unsigned OFF_W       = $clog2(BURST_COUNT);
  localparam int unsigned LINE_ADDR_W = DEPTH_BITWIDTH - OFF_W;
  localparam int unsigned LINE_W      = BURST_COUNT * DATA_BITWIDTH;

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic [LINE_ADDR_W-1:0]     req_line_addr;
  logic [LINE_W-1:0]          req_wr_line;
  logic                       resp_valid;
  logic                       resp_error;
  logic [LINE_W-1:0]          resp_rd_line;
  logic                       ram_cmd;
  logic                       ram_cmd_en;
  logic [DEPTH_BITWIDTH-1:0]  ram_addr;
  logic [DATA_BITWIDTH-1:0]   ram_wr_data;
  logic [DATA_BITWIDTH/8-1:0] ram_data_mask;
  logic [DATA_BITWIDTH-1:0]   ram_rd_data;
  logic                       ram_rd_data_valid;
  logic                       ram_busy;

  modport master (
    input  req_valid, req_write, req_line_addr, req_wr_line,
    input  ram_rd_data, ram_rd_data_valid, ram_busy,
    output req_ready, resp_valid, resp_error, resp_rd_line,
    output ram_cmd, ram_cmd_en, ram_addr, ram_wr_data, ram_data_mask
  );

  modport slave (
    output req_valid, req_write, req_line_addr, req_wr_line,
    output ram_rd_data, ram_rd_data_valid, ram_busy,
    input  req_ready, resp_valid, resp_error, resp_rd_line,
    input  ram_cmd, ram_cmd_en, ram_addr, ram_wr_data, ram_data_mask
  );
endinterface

// File: rtl/burst_line_master.sv
// Cache-line burst initiator: turns one host line read/write into one burst-RAM command,
// streams or collects BURST_COUNT words, and returns a single registered response.
module burst_line_master #(
  parameter int unsigned DEPTH_BITWIDTH = 4,
  parameter int unsigned DATA_BITWIDTH  = 64,
  parameter int unsigned BURST_COUNT    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                 clk,
  input logic                 rst,
  burst_line_master_if.master bus
);
  localparam int unsigned OFF_W       = $clog2(BURST_COUNT);
  localparam int unsigned LINE_ADDR_W = DEPTH_BITWIDTH - OFF_W;
  localparam int unsigned LINE_W      = BURST_COUNT * DATA_BITWIDTH;
  localparam int unsigned CNT_W       = OFF_W + 1;
  localparam int unsigned TMR_W       = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWrBurst, StRdWait, StResp} state_e;

  state_e                    state_q;
  logic [LINE_W-1:0]         wr_line_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [TMR_W-1:0]          tmr_q;
  logic [LINE_W-1:0]         rd_buf_q;
  logic                      cmd_en_q;
  logic                      cmd_q;
  logic [DEPTH_BITWIDTH-1:0] addr_q;
  logic [DATA_BITWIDTH-1:0]  wr_data_q;
  logic                      resp_valid_q;
  logic                      resp_error_q;
  logic [LINE_W-1:0]         resp_line_q;

  logic                      req_ready;
  logic [OFF_W-1:0]          slot;
  logic [OFF_W-1:0]          nxt_idx;
  logic [DATA_BITWIDTH-1:0]  wr_word_nxt;
  logic [LINE_W-1:0]         rd_line_nxt;
  logic [LINE_W-1:0]         rd_buf_nxt;
  logic                      rd_last;
  logic                      timed_out;

  assign req_ready = (state_q == StIdle) && !bus.ram_busy;
  assign slot      = cnt_q[OFF_W-1:0];
  assign nxt_idx   = slot + OFF_W'(1);
  assign rd_last   = bus.ram_rd_data_valid && (cnt_q == CNT_W'(BURST_COUNT - 1));
  assign timed_out = (tmr_q == TMR_W'(TIMEOUT_CYCLES));

  // During a write cnt_q indexes the word currently on ram_wr_data; during a read it is the
  // number of words already collected, so slot is where the next arriving word lands.
  always_comb begin
    wr_word_nxt = '0;
    rd_line_nxt = rd_buf_q;
    for (int unsigned i = 0; i < BURST_COUNT; i++) begin
      if (OFF_W'(i) == nxt_idx) wr_word_nxt = wr_line_q[i*DATA_BITWIDTH +: DATA_BITWIDTH];
      if (OFF_W'(i) == slot) rd_line_nxt[i*DATA_BITWIDTH +: DATA_BITWIDTH] = bus.ram_rd_data;
    end
    rd_buf_nxt = bus.ram_rd_data_valid ? rd_line_nxt : rd_buf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_line_q    <= '0;
      cnt_q        <= '0;
      tmr_q        <= '0;
      rd_buf_q     <= '0;
      cmd_en_q     <= 1'b0;
      cmd_q        <= 1'b0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_line_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid && req_ready) begin
            state_q   <= StIssue;
            wr_line_q <= bus.req_wr_line;
            cmd_q     <= bus.req_write;
            addr_q    <= {bus.req_line_addr, OFF_W'(0)};
            wr_data_q <= bus.req_wr_line[DATA_BITWIDTH-1:0];
            cmd_en_q  <= 1'b1;
            cnt_q     <= '0;
          end
        end
        StIssue: begin
          cmd_en_q <= 1'b0;
          if (cmd_q) begin
            state_q   <= StWrBurst;
            wr_data_q <= wr_word_nxt;
            cnt_q     <= CNT_W'(1);
          end else begin
            state_q   <= StRdWait;
            wr_data_q <= '0;
            rd_buf_q  <= '0;
            cnt_q     <= '0;
            tmr_q     <= TMR_W'(1);
          end
        end
        StWrBurst: begin
          if (cnt_q == CNT_W'(BURST_COUNT - 1)) begin
            state_q      <= StResp;
            wr_data_q    <= '0;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b0;
          end else begin
            wr_data_q <= wr_word_nxt;
            cnt_q     <= cnt_q + CNT_W'(1);
          end
        end
        StRdWait: begin
          tmr_q <= tmr_q + TMR_W'(1);
          if (bus.ram_rd_data_valid) begin
            rd_buf_q <= rd_line_nxt;
            cnt_q    <= cnt_q + CNT_W'(1);
          end
          // A final word arriving on the timeout cycle still counts as a clean completion.
          if (rd_last || timed_out) begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
            resp_error_q <= !rd_last;
            resp_line_q  <= rd_buf_nxt;
          end
        end
        StResp: begin
          state_q      <= StIdle;
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_error    = resp_error_q;
  assign bus.resp_rd_line  = resp_line_q;
  assign bus.ram_cmd       = cmd_q;
  assign bus.ram_cmd_en    = cmd_en_q;
  assign bus.ram_addr      = addr_q;
  assign bus.ram_wr_data   = wr_data_q;
  assign bus.ram_data_mask = '0;
endmodule

// File: tb/tb_burst_line_master.sv
// Bench for burst_line_master: behavioural burst RAM (read data 10..13 cycles after the
// command), a table of line transactions, and hand sequences for hold, timeout and reset.
module tb_burst_line_master;
  localparam int unsigned LW = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  burst_line_master_if #(.DEPTH_BITWIDTH(4), .DATA_BITWIDTH(64), .BURST_COUNT(4)) bus ();

  burst_line_master #(
    .DEPTH_BITWIDTH(4),
    .DATA_BITWIDTH (64),
    .BURST_COUNT   (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Burst RAM model: registered responder, word address = line address + beat.
  logic [63:0] mem [16];
  logic        m_init = 1'b0;
  logic        m_act, m_wr;
  logic [3:0]  m_addr;
  int          m_k;
  int          words_to_send = 4;
  int          stray_cnt = 0;
  int          stray_done = 0;

  always @(posedge clk) begin
    if (rst) begin
      if (!m_init) begin
        for (int i = 0; i < 16; i++) mem[i] = 64'(i);
        m_init = 1'b1;
      end
      m_act <= 1'b0;
      m_wr <= 1'b0;
      m_addr <= '0;
      m_k <= 0;
      bus.ram_busy <= 1'b0;
      bus.ram_rd_data_valid <= 1'b0;
      bus.ram_rd_data <= '0;
    end else begin
      bus.ram_rd_data_valid <= 1'b0;
      if (stray_cnt != stray_done) begin
        stray_done = stray_cnt;
        bus.ram_rd_data_valid <= 1'b1;
        bus.ram_rd_data <= 64'hDEAD;
      end
      if (bus.ram_cmd_en) begin
        m_act <= 1'b1;
        m_k <= 1;
        m_wr <= bus.ram_cmd;
        m_addr <= bus.ram_addr;
        bus.ram_busy <= 1'b1;
        if (bus.ram_cmd) mem[bus.ram_addr] = bus.ram_wr_data;
      end else if (m_act) begin
        m_k <= m_k + 1;
        if (m_wr) begin
          if (m_k < 4) mem[m_addr + 4'(m_k)] = bus.ram_wr_data;
          if (m_k + 1 == 10) begin
            bus.ram_busy <= 1'b0;
            m_act <= 1'b0;
          end
        end else begin
          if (m_k + 1 >= 10 && m_k + 1 < 14 && (m_k + 1 - 10) < words_to_send) begin
            bus.ram_rd_data_valid <= 1'b1;
            bus.ram_rd_data <= mem[m_addr + 4'(m_k - 9)];
          end
          if (m_k + 1 == 14) begin
            bus.ram_busy <= 1'b0;
            m_act <= 1'b0;
          end
        end
      end
    end
  end

  // Monitor: samples registered outputs mid-cycle.
  int          cyc = 0;
  int          n_acc = 0, n_cmd = 0, n_resp = 0, ready_viol = 0;
  int          acc_cyc, cmd_cyc, resp_cyc, last_busy_cyc;
  logic [3:0]  cmd_addr;
  logic        cmd_w, resp_err;
  logic [LW-1:0] resp_line;
  logic [63:0] wd_log [64];

  always @(negedge clk) begin
    if (bus.req_valid && bus.req_ready) begin
      acc_cyc = cyc;
      n_acc++;
    end
    if (bus.ram_cmd_en) begin
      cmd_cyc = cyc;
      n_cmd++;
      cmd_addr = bus.ram_addr;
      cmd_w = bus.ram_cmd;
    end
    if (bus.resp_valid) begin
      resp_cyc = cyc;
      n_resp++;
      resp_err = bus.resp_error;
      resp_line = bus.resp_rd_line;
    end
    if (bus.req_ready && bus.ram_busy) ready_viol++;
    if (bus.ram_busy) last_busy_cyc = cyc;
    wd_log[cyc[5:0]] = bus.ram_wr_data;
    cyc++;
  end

  task automatic run_req(input string name, input logic w, input logic [1:0] line,
                         input logic [LW-1:0] wl);
    int a0, r0;
    a0 = n_acc;
    r0 = n_resp;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_line_addr = line;
    bus.req_wr_line = wl;
    for (int i = 0; i < 60 && n_acc == a0; i++) begin
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    check({name, " accepted"}, LW'(n_acc - a0), LW'(1));
    for (int i = 0; i < 60 && n_resp == r0; i++) begin
      @(posedge clk); #1;
    end
    check({name, " responded"}, LW'(n_resp - r0), LW'(1));
  endtask

  typedef struct {
    string         name;
    logic          w;
    logic [1:0]    line;
    logic [LW-1:0] wl;
    logic          err;
    logic [LW-1:0] exp_line;
    int            lat;
  } vec_t;

  vec_t vecs[6];
  logic [LW-1:0] wl1, wl2, wl3, wl4, line0, line3;

  initial begin
    int c0, a0, r0, cmd1;
    wl1   = {64'h44, 64'h33, 64'h22, 64'h11};
    wl2   = {64'hD4, 64'hD3, 64'hD2, 64'hD1};
    wl3   = {64'hE4, 64'hE3, 64'hE2, 64'hE1};
    wl4   = {64'hF4, 64'hF3, 64'hF2, 64'hF1};
    line0 = {64'd3, 64'd2, 64'd1, 64'd0};
    line3 = {64'd15, 64'd14, 64'd13, 64'd12};
    vecs[0] = '{"wr_line1", 1'b1, 2'd1, wl1, 1'b0, '0,    5};
    vecs[1] = '{"rd_line1", 1'b0, 2'd1, '0,  1'b0, wl1,  15};
    vecs[2] = '{"wr_line2", 1'b1, 2'd2, wl2, 1'b0, wl1,   5};
    vecs[3] = '{"rd_line3", 1'b0, 2'd3, '0,  1'b0, line3, 15};
    vecs[4] = '{"rd_line2", 1'b0, 2'd2, '0,  1'b0, wl2,  15};
    vecs[5] = '{"rd_line0", 1'b0, 2'd0, '0,  1'b0, line0, 15};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_line_addr = '0;
    bus.req_wr_line = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset outputs", {bus.resp_valid, bus.resp_error, bus.ram_cmd, bus.ram_cmd_en,
          bus.ram_addr, bus.ram_wr_data, bus.ram_data_mask}, '0);
    check("reset rd_line", bus.resp_rd_line, '0);
    check("reset req_ready", LW'(bus.req_ready), LW'(1));

    for (int v = 0; v < 6; v++) begin
      c0 = n_cmd;
      run_req(vecs[v].name, vecs[v].w, vecs[v].line, vecs[v].wl);
      check({vecs[v].name, " one cmd"}, LW'(n_cmd - c0), LW'(1));
      check({vecs[v].name, " cmd lat"}, LW'(cmd_cyc - acc_cyc), LW'(1));
      check({vecs[v].name, " cmd type"}, LW'(cmd_w), LW'(vecs[v].w));
      check({vecs[v].name, " addr"}, LW'(cmd_addr), LW'({vecs[v].line, 2'b00}));
      check({vecs[v].name, " resp lat"}, LW'(resp_cyc - acc_cyc), LW'(vecs[v].lat));
      check({vecs[v].name, " err"}, LW'(resp_err), LW'(vecs[v].err));
      check({vecs[v].name, " line"}, resp_line, vecs[v].exp_line);
      if (vecs[v].w) begin
        for (int i = 0; i < 4; i++)
          check($sformatf("%s word%0d", vecs[v].name, i), LW'(wd_log[6'(cmd_cyc + i)]),
                LW'(vecs[v].wl[i*64 +: 64]));
      end
    end

    // Request held valid: the read behind a write must wait for ram_busy to drop.
    c0 = n_cmd;
    a0 = n_acc;
    r0 = n_resp;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_line_addr = 2'd2;
    bus.req_wr_line = wl3;
    for (int i = 0; i < 60 && n_acc == a0; i++) begin
      @(posedge clk); #1;
    end
    bus.req_write = 1'b0;
    bus.req_wr_line = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmd1 = cmd_cyc;
    for (int i = 0; i < 60 && n_acc < a0 + 2; i++) begin
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    check("hold two accepts", LW'(n_acc - a0), LW'(2));
    check("hold accept after busy", LW'(acc_cyc - cmd1), LW'(10));
    check("hold busy before accept", LW'(last_busy_cyc < acc_cyc), LW'(1));
    for (int i = 0; i < 60 && n_resp < r0 + 2; i++) begin
      @(posedge clk); #1;
    end
    check("hold two cmds", LW'(n_cmd - c0), LW'(2));
    check("hold read line", resp_line, wl3);
    check("ready while busy", LW'(ready_viol), LW'(0));

    // Silent responder: timeout error with an all-zero line.
    words_to_send = 0;
    run_req("timeout silent", 1'b0, 2'd1, '0);
    check("timeout lat", LW'(resp_cyc - cmd_cyc), LW'(17));
    check("timeout err", LW'(resp_err), LW'(1));
    check("timeout line", resp_line, '0);

    // Two of four words then silence: partial line, later stray word ignored.
    words_to_send = 2;
    run_req("timeout partial", 1'b0, 2'd1, '0);
    check("partial err", LW'(resp_err), LW'(1));
    check("partial line", resp_line, {128'd0, 64'h22, 64'h11});
    words_to_send = 4;
    r0 = n_resp;
    stray_cnt++;
    repeat (6) @(posedge clk);
    #1;
    check("stray no resp", LW'(n_resp - r0), LW'(0));
    check("stray line held", bus.resp_rd_line, {128'd0, 64'h22, 64'h11});

    // Reset while word2 of a write is on the bus.
    a0 = n_acc;
    r0 = n_resp;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_line_addr = 2'd2;
    bus.req_wr_line = wl4;
    for (int i = 0; i < 60 && n_acc == a0; i++) begin
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst word2 on bus", LW'(bus.ram_wr_data), LW'(64'hF3));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst outputs", {bus.resp_valid, bus.resp_error, bus.ram_cmd, bus.ram_cmd_en,
          bus.ram_addr, bus.ram_wr_data}, '0);
    check("rst rd_line", bus.resp_rd_line, '0);
    c0 = n_cmd;
    repeat (20) @(posedge clk);
    #1;
    check("rst no resp", LW'(n_resp - r0), LW'(0));
    check("rst no cmd", LW'(n_cmd - c0), LW'(0));
    run_req("post rst read", 1'b0, 2'd0, '0);
    check("post rst lat", LW'(resp_cyc - acc_cyc), LW'(15));
    check("post rst err", LW'(resp_err), LW'(0));
    check("post rst line", resp_line, line0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1);
  end
endmodule
